// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg
// Shared types and constants for the MIPS CPU instruction memory.
//   state_e      : loader/run state of the instruction memory
//   RESET_VECTOR : byte address of the first instruction fetched after reset
//   NOP          : word returned for any fetch that has no valid backing word
//   byte_swap()  : reverses byte lanes of a 32-bit word
package mips_cpu_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] NOP          = 32'h00000000;

    // Program words arrive big-endian; the CPU consumes little-endian lanes.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mips_cpu_instr_mem_array.sv
// mips_cpu_instr_mem_array
// Word-addressed storage: one synchronous write port, one combinational
// read port, synchronous clear of every word.
//   clk     : rising-edge clock
//   clear_i : synchronous clear of all words (wins over a write)
//   we_i    : write enable
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : read word index
//   rdata_o : read data (combinational)
module mips_cpu_instr_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clear_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_cpu_instr_memory.sv
// mips_cpu_instr_memory
// Boot instruction memory for a MIPS CPU. A loader streams program words in
// while the CPU is held in reset (LOAD); the CPU then fetches from it (RUN).
//   clk, reset     : clock, synchronous active-high reset
//   instr_address  : CPU fetch byte address
//   instr_readdata : fetched word, byte-reversed for the CPU
//   load_valid/ready/data/last : loader beat handshake
//   load_start     : request to reload while running
//   cpu_reset      : CPU reset, high while loading plus one cycle into RUN
//   load_done      : high in RUN
//   fetch_fault    : sticky bad-fetch flag
// Optional feature macro: INSTR_MEM_FAULT_EN enables fetch_fault detection;
// without it fetch_fault is tied low.
module mips_cpu_instr_memory
    import mips_cpu_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        load_start,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        fetch_fault
);

    localparam int            AW       = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          beat_acc;
    logic [31:0]   word_idx;
    logic          idx_in_range;
    logic [31:0]   rd_word;

    assign beat_acc = (state_q == ST_LOAD) && load_valid;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign word_idx     = (instr_address - BASE_ADDR) >> 2;
    assign idx_in_range = word_idx < 32'(DEPTH_WORDS);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        case (state_q)
            ST_LOAD: begin
                if (beat_acc) begin
                    // Pointer holds at the last word so it can never wrap.
                    if (load_last || wr_ptr_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // High for every LOAD cycle and for the first RUN cycle, so the CPU
    // sees one reset-high cycle with the finished program visible.
    assign cpu_reset_d = (state_q == ST_LOAD) || (state_d == ST_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    mips_cpu_instr_mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .clear_i (reset),
        .we_i    (beat_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_data),
        .raddr_i (word_idx[AW-1:0]),
        .rdata_o (rd_word)
    );

    assign instr_readdata = (state_q == ST_RUN && idx_in_range) ? byte_swap(rd_word) : NOP;
    assign load_ready     = (state_q == ST_LOAD);
    assign load_done      = (state_q == ST_RUN);
    assign cpu_reset      = cpu_reset_q;

`ifdef INSTR_MEM_FAULT_EN
    logic fetch_fault_q;

    // Address 0 is the halt target, so only a misaligned fetch faults there.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_fault_q <= 1'b0;
        end else if (state_q == ST_RUN && !cpu_reset_q &&
                     (instr_address[1:0] != 2'b00 ||
                      (!idx_in_range && instr_address != 32'h0))) begin
            fetch_fault_q <= 1'b1;
        end
    end

    assign fetch_fault = fetch_fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
